// File: rtl/minesweeper_pkg.sv
// Shared minesweeper definitions: cell display codes, game states, board defaults and the
// mine-placement LFSR step.
package minesweeper_pkg;

  localparam int unsigned GRID_W_DEFAULT = 8;
  localparam int unsigned GRID_H_DEFAULT = 8;

  localparam logic [3:0] CELL_HIDDEN = 4'd9;
  localparam logic [3:0] CELL_FLAG   = 4'd10;
  localparam logic [3:0] CELL_MINE   = 4'd11;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    StPlace = 2'd0,
    StPlay  = 2'd1,
    StWin   = 2'd2,
    StLose  = 2'd3
  } game_state_e;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting towards bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Level debouncer: emits a single-cycle pulse once the raw input has been asserted for
// CYCLES consecutive clocks. Deassertion restarts the count; release produces no pulse.
module key_debounce #(
  parameter int unsigned CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse
);

  localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             fired_q;
  logic             pulse_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      fired_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (!raw) begin
        cnt_q   <= '0;
        fired_q <= 1'b0;
      end else if (!fired_q) begin
        // fired_q holds off further pulses until the input is released
        if (cnt_q == CNT_W'(CYCLES - 1)) begin
          pulse_q <= 1'b1;
          fired_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign pulse = pulse_q;

endmodule

// File: rtl/board_state_ctrl.sv
// Minesweeper board controller: LFSR mine placement, cursor, reveal/flag handling and a
// registered cell readout port. Define FLAG_EN to build in cell flagging.
module board_state_ctrl
  import minesweeper_pkg::*;
#(
  parameter int unsigned GRID_W          = GRID_W_DEFAULT,
  parameter int unsigned GRID_H          = GRID_H_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned MINE_DENSITY    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic       btn_reveal,
  input  logic       btn_flag,
  input  logic [2:0] rd_col,
  input  logic [2:0] rd_row,
  output logic [3:0] rd_cell,
  output logic [2:0] cursor_x,
  output logic [2:0] cursor_y,
  output logic [1:0] game_state,
  output logic [6:0] mines_total
);

  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;

  // Debounced press pulses; key_pulse bit order matches key_n.
  logic [3:0] key_pulse;
  logic       reveal_pulse;
  logic       flag_pulse;

  for (genvar k = 0; k < 4; k++) begin : g_key_db
    key_debounce #(
      .CYCLES(DEBOUNCE_CYCLES)
    ) u_key_db (
      .clk  (clk),
      .rst  (rst),
      .raw  (~key_n[k]),
      .pulse(key_pulse[k])
    );
  end

  key_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_reveal_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_reveal),
    .pulse(reveal_pulse)
  );

  game_state_e      state_q, state_d;
  logic [15:0]      lfsr_q;
  logic [IDX_W-1:0] place_idx_q;
  logic [6:0]       mines_total_q;
  logic [6:0]       revealed_cnt_q;
  logic [2:0]       cursor_x_q, cursor_x_d;
  logic [2:0]       cursor_y_q, cursor_y_d;
  logic [3:0]       rd_cell_q, rd_cell_d;

  logic             mine_q     [CELLS];
  logic             revealed_q [CELLS];
  logic [3:0]       adj_q      [CELLS];

  logic [IDX_W-1:0] cur_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             cur_flagged;
  logic             rd_flagged;
  logic             place_mine;
  logic             place_en;
  logic             reveal_en;
  logic             flag_toggle;
  logic [3:0]       adj_cnt;
  logic [6:0]       win_target;

  assign cur_idx    = IDX_W'(32'(cursor_y_q) * GRID_W + 32'(cursor_x_q));
  assign rd_idx     = IDX_W'(32'(rd_row) * GRID_W + 32'(rd_col));
  assign place_mine = (32'(lfsr_q[3:0]) < MINE_DENSITY);
  assign win_target = 7'(CELLS) - mines_total_q;

`ifdef FLAG_EN
  logic flagged_q [CELLS];

  key_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_flag_db (
    .clk  (clk),
    .rst  (rst),
    .raw  (btn_flag),
    .pulse(flag_pulse)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(CELLS); i++) begin
        flagged_q[i] <= 1'b0;
      end
    end else if (flag_toggle) begin
      flagged_q[cur_idx] <= ~flagged_q[cur_idx];
    end
  end

  assign cur_flagged = flagged_q[cur_idx];
  assign rd_flagged  = flagged_q[rd_idx];
`else
  logic unused_btn_flag;

  assign unused_btn_flag = btn_flag;
  assign flag_pulse      = 1'b0;
  assign cur_flagged     = 1'b0;
  assign rd_flagged      = 1'b0;
`endif

  // Mined neighbours of the cursor cell, clipped at the board edges.
  always_comb begin
    int nx, ny;
    adj_cnt = '0;
    nx      = 0;
    ny      = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        nx = int'(cursor_x_q) + dx;
        ny = int'(cursor_y_q) + dy;
        if (!(dx == 0 && dy == 0) && nx >= 0 && nx < int'(GRID_W) &&
            ny >= 0 && ny < int'(GRID_H)) begin
          if (mine_q[IDX_W'(ny * int'(GRID_W) + nx)]) begin
            adj_cnt = adj_cnt + 4'd1;
          end
        end
      end
    end
  end

  // Next state: one event per cycle, reveal > flag > left > right > up > down.
  always_comb begin
    state_d     = state_q;
    cursor_x_d  = cursor_x_q;
    cursor_y_d  = cursor_y_q;
    place_en    = 1'b0;
    reveal_en   = 1'b0;
    flag_toggle = 1'b0;
    unique case (state_q)
      StPlace: begin
        place_en = 1'b1;
        if (place_idx_q == IDX_W'(CELLS - 1)) begin
          state_d = StPlay;
        end
      end
      StPlay: begin
        if (revealed_cnt_q == win_target) begin
          state_d = StWin;
        end else if (reveal_pulse) begin
          if (!revealed_q[cur_idx] && !cur_flagged) begin
            if (mine_q[cur_idx]) begin
              state_d = StLose;
            end else begin
              reveal_en = 1'b1;
            end
          end
        end else if (flag_pulse) begin
          flag_toggle = !revealed_q[cur_idx];
        end else if (key_pulse[3]) begin
          if (cursor_x_q != 3'd0) cursor_x_d = cursor_x_q - 3'd1;
        end else if (key_pulse[2]) begin
          if (cursor_x_q != 3'(GRID_W - 1)) cursor_x_d = cursor_x_q + 3'd1;
        end else if (key_pulse[1]) begin
          if (cursor_y_q != 3'd0) cursor_y_d = cursor_y_q - 3'd1;
        end else if (key_pulse[0]) begin
          if (cursor_y_q != 3'(GRID_H - 1)) cursor_y_d = cursor_y_q + 3'd1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_cell_d = CELL_HIDDEN;
    if (32'(rd_col) < GRID_W && 32'(rd_row) < GRID_H) begin
      if (revealed_q[rd_idx]) begin
        rd_cell_d = adj_q[rd_idx];
      end else if (mine_q[rd_idx] && state_q == StLose) begin
        rd_cell_d = CELL_MINE;
      end else if (rd_flagged) begin
        rd_cell_d = CELL_FLAG;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StPlace;
      lfsr_q         <= LFSR_SEED;
      place_idx_q    <= '0;
      mines_total_q  <= '0;
      revealed_cnt_q <= '0;
      cursor_x_q     <= '0;
      cursor_y_q     <= '0;
      rd_cell_q      <= CELL_HIDDEN;
      for (int i = 0; i < int'(CELLS); i++) begin
        mine_q[i]     <= 1'b0;
        revealed_q[i] <= 1'b0;
        adj_q[i]      <= '0;
      end
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_step(lfsr_q);
      cursor_x_q <= cursor_x_d;
      cursor_y_q <= cursor_y_d;
      rd_cell_q  <= rd_cell_d;
      if (place_en) begin
        mine_q[place_idx_q] <= place_mine;
        place_idx_q         <= place_idx_q + 1'b1;
        if (place_mine) mines_total_q <= mines_total_q + 7'd1;
      end
      if (reveal_en) begin
        revealed_q[cur_idx] <= 1'b1;
        adj_q[cur_idx]      <= adj_cnt;
        revealed_cnt_q      <= revealed_cnt_q + 7'd1;
      end
    end
  end

  assign rd_cell     = rd_cell_q;
  assign cursor_x    = cursor_x_q;
  assign cursor_y    = cursor_y_q;
  assign game_state  = state_q;
  assign mines_total = mines_total_q;

endmodule

// File: tb/tb_board_state_ctrl.sv
// Self-checking bench for board_state_ctrl against a behavioural board model.
module tb_board_state_ctrl;

  localparam int DEB  = 4;
  localparam int W    = 8;
  localparam int H    = 8;
  localparam int N    = W * H;
  localparam int DENS = 2;
`ifdef FLAG_EN
  localparam bit FLAG = 1'b1;
`else
  localparam bit FLAG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_n;
  logic       btn_reveal;
  logic       btn_flag;
  logic [2:0] rd_col;
  logic [2:0] rd_row;
  logic [3:0] rd_cell;
  logic [2:0] cursor_x;
  logic [2:0] cursor_y;
  logic [1:0] game_state;
  logic [6:0] mines_total;

  always #5 clk = ~clk;

  board_state_ctrl #(
    .GRID_W(W),
    .GRID_H(H),
    .DEBOUNCE_CYCLES(DEB),
    .MINE_DENSITY(DENS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .btn_reveal (btn_reveal),
    .btn_flag   (btn_flag),
    .rd_col     (rd_col),
    .rd_row     (rd_row),
    .rd_cell    (rd_cell),
    .cursor_x   (cursor_x),
    .cursor_y   (cursor_y),
    .game_state (game_state),
    .mines_total(mines_total)
  );

  int checks = 0;
  int errors = 0;

  // Model: 0 place, 1 play, 2 win, 3 lose
  bit m_mine[N];
  bit m_rev[N];
  bit m_flag[N];
  int m_total;
  int m_revcnt;
  int m_state;
  int mx, my;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void gen_layout();
    int l;
    l = 'hACE1;
    m_total = 0;
    for (int i = 0; i < N; i++) begin
      m_mine[i] = ((l % 16) < DENS);
      m_total += int'(m_mine[i]);
      l = (l >> 1) | (((l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1) << 15);
    end
  endfunction

  function automatic int model_adj(input int c);
    int x, y, n;
    x = c % W;
    y = c / W;
    n = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
          if (m_mine[(y + dy) * W + x + dx]) n++;
    return n;
  endfunction

  function automatic int model_code(input int c);
    if (m_rev[c]) return model_adj(c);
    if (m_mine[c] && m_state == 3) return 11;
    if (m_flag[c]) return 10;
    return 9;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_rev[i]  = 1'b0;
      m_flag[i] = 1'b0;
    end
    m_revcnt = 0;
    m_state  = 0;
    mx = 0;
    my = 0;
  endfunction

  function automatic void model_press(input bit rev, input bit flg, input logic [3:0] dirs);
    int c;
    c = my * W + mx;
    if (m_state != 1) return;
    if (rev) begin
      if (!m_rev[c] && !m_flag[c]) begin
        if (m_mine[c]) m_state = 3;
        else begin
          m_rev[c] = 1'b1;
          m_revcnt++;
        end
      end
    end else if (flg && FLAG) begin
      if (!m_rev[c]) m_flag[c] = !m_flag[c];
    end else if (dirs[3]) mx = (mx > 0) ? mx - 1 : 0;
    else if (dirs[2]) mx = (mx < W - 1) ? mx + 1 : W - 1;
    else if (dirs[1]) my = (my > 0) ? my - 1 : 0;
    else if (dirs[0]) my = (my < H - 1) ? my + 1 : H - 1;
    if (m_state == 1 && m_revcnt == N - m_total) m_state = 2;
  endfunction

  // Hold the given inputs for `hold` clock edges, then release and settle.
  task automatic press(input bit rev, input bit flg, input logic [3:0] dirs, input int hold);
    btn_reveal = rev;
    btn_flag   = flg;
    key_n      = ~dirs;
    repeat (hold) @(negedge clk);
    btn_reveal = 1'b0;
    btn_flag   = 1'b0;
    key_n      = 4'hF;
    repeat (2) @(negedge clk);
  endtask

  task automatic act(input bit rev, input bit flg, input logic [3:0] dirs);
    press(rev, flg, dirs, DEB + 1);
    model_press(rev, flg, dirs);
  endtask

  task automatic move_to(input int tx, input int ty);
    for (int i = 0; i < 16 && mx != tx; i++) act(1'b0, 1'b0, (tx < mx) ? 4'b1000 : 4'b0100);
    for (int i = 0; i < 16 && my != ty; i++) act(1'b0, 1'b0, (ty < my) ? 4'b0010 : 4'b0001);
  endtask

  task automatic check_cell(input string tag, input int c);
    rd_col = 3'(c % W);
    rd_row = 3'(c / W);
    @(negedge clk);
    check(tag, rd_cell, model_code(c));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
  endtask

  task automatic wait_place();
    int n;
    n = 0;
    while (game_state == 2'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("place_cycles", n, 64);
    m_state = 1;
    check("play_after_place", game_state, 1);
    check("mines_total", mines_total, m_total);
  endtask

  initial begin
    int target, prefix, best;
    logic [3:0] d;

    rst = 1'b1;
    key_n = 4'hF;
    btn_reveal = 1'b0;
    btn_flag = 1'b0;
    rd_col = '0;
    rd_row = '0;
    gen_layout();
    @(negedge clk);
    do_reset();
    check("reset_rd_cell", rd_cell, 9);
    check("reset_cursor_x", cursor_x, 0);
    check("reset_cursor_y", cursor_y, 0);
    check("reset_mines", mines_total, 0);
    check("reset_state", game_state, 0);
    rst = 1'b0;
    wait_place();

    // Short press filtered, then saturation at the left edge, then walk right.
    press(1'b0, 1'b0, 4'b1000, 3);
    check("short_press_x", cursor_x, 0);
    check("short_press_y", cursor_y, 0);
    act(1'b0, 1'b0, 4'b1000);
    press(1'b0, 1'b0, 4'b1000, 1);
    check("left_sat_x", cursor_x, 0);
    for (int i = 0; i < 10; i++) act(1'b0, 1'b0, 4'b0100);
    check("right_sat_x", cursor_x, 7);

    for (int i = 0; i < 16; i++) begin
      d = 4'b0001 << $urandom_range(0, 3);
      act(1'b0, 1'b0, d);
      check("rand_move_x", cursor_x, mx);
      check("rand_move_y", cursor_y, my);
    end

    // Reveal a safe cell, preferring one with exactly two mined neighbours.
    target = -1;
    best = -1;
    for (int c = 0; c < N; c++)
      if (!m_mine[c]) begin
        if (model_adj(c) == 2 && target < 0) target = c;
        if (best < 0 || model_adj(c) > model_adj(best)) best = c;
      end
    if (target < 0) target = best;
    move_to(target % W, target / W);
    act(1'b1, 1'b0, 4'b0000);
    check_cell("reveal_adj", target);
    act(1'b1, 1'b0, 4'b0000);
    check_cell("re_reveal_adj", target);
    check("re_reveal_state", game_state, 1);

    // Flagging on cell 0, which the seed always mines.
    move_to(0, 0);
`ifdef FLAG_EN
    act(1'b0, 1'b1, 4'b0000);
    check("flag_set", rd_cell, 9);
    check_cell("flag_read", 0);
    check("flag_read_lit", rd_cell, 10);
    act(1'b1, 1'b0, 4'b0000);
    check_cell("flag_reveal_blocked", 0);
    check("flag_reveal_state", game_state, 1);
    act(1'b0, 1'b1, 4'b0000);
    check_cell("flag_cleared", 0);
    check("flag_cleared_lit", rd_cell, 9);
`else
    act(1'b0, 1'b1, 4'b0100);
    check_cell("flag_ignored", 0);
    check("flag_ignored_x", cursor_x, mx);
    move_to(0, 0);
`endif

    // Reveal every safe cell with a random same-cycle direction that must be dropped.
    for (int y = 0; y < H; y++) begin
      for (int i = 0; i < W; i++) begin
        int x, c;
        x = (y % 2 == 0) ? i : W - 1 - i;
        c = y * W + x;
        if (!m_mine[c] && !m_rev[c] && m_state == 1) begin
          move_to(x, y);
          d = 4'b0001 << $urandom_range(0, 3);
          act(1'b1, 1'b0, d);
          check("reveal_prio_x", cursor_x, mx);
          check("reveal_prio_y", cursor_y, my);
        end
      end
    end
    check("win_state", game_state, 2);
    check("win_model", game_state, m_state);
    for (int c = 0; c < N; c++) check_cell("win_board", c);
    act(1'b1, 1'b0, (mx > 0) ? 4'b1000 : 4'b0100);
    check("win_frozen_x", cursor_x, mx);
    check("win_frozen_state", game_state, 2);

    // Reset mid-placement, then confirm the layout is regenerated identically.
    do_reset();
    rst = 1'b0;
    repeat (30) @(negedge clk);
    prefix = 0;
    for (int c = 0; c < 30; c++) prefix += int'(m_mine[c]);
    check("mid_place_state", game_state, 0);
    check("mid_place_mines", mines_total, prefix);
    do_reset();
    rst = 1'b0;
    wait_place();

    target = 0;
    for (int k = $urandom_range(0, N - 1), n = 0; n < N; n++)
      if (m_mine[(k + n) % N]) begin
        target = (k + n) % N;
        break;
      end
    move_to(target % W, target / W);
    btn_reveal = 1'b1;
    repeat (DEB) @(negedge clk);
    check("lose_before", game_state, 1);
    @(negedge clk);
    check("lose_next_cycle", game_state, 3);
    btn_reveal = 1'b0;
    repeat (2) @(negedge clk);
    m_state = 3;
    for (int c = 0; c < N; c++) check_cell("lose_board", c);
    act(1'b0, 1'b0, (mx > 0) ? 4'b1000 : 4'b0100);
    act(1'b1, 1'b0, 4'b0000);
    check("lose_frozen_x", cursor_x, mx);
    check("lose_frozen_y", cursor_y, my);
    check("lose_frozen_state", game_state, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
